// File: rtl/phase_unwrap_scheduler.sv
// Round-robin scheduler sharing one phase-unwrap datapath between NCH channels.
// Samples wait in one-entry holding registers and are issued as single-cycle
// tagged strobes. Results are routed back by channel through a tag pipeline
// whose depth matches the datapath latency.
module phase_unwrap_scheduler #(
    parameter int  NCH     = 4,
    parameter int  W       = 32,
    parameter int  RW      = 16,
    parameter int  LATENCY = 7,
    parameter int  GAP     = 2,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [NCH*W-1:0]     ch_phase,
    input  logic [NCH-1:0]       ch_valid,
    output logic [NCH-1:0]       ch_ready,
    output logic signed [W-1:0]  dp_phase,
    output logic                 dp_en,
    output logic [CW-1:0]        dp_ch,
    input  logic signed [RW-1:0] dp_res,
    input  logic                 dp_res_en,
    output logic signed [RW-1:0] out_data,
    output logic [CW-1:0]        out_ch,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 err_orphan,
    output logic                 err_missing
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    state_t                state_q, state_d;
    logic [3:0]            gap_q, gap_d;
    logic [NCH-1:0]        full_q, full_d, accept;
    logic signed [W-1:0]   hold_q [NCH];
    logic [CW-1:0]         rr_q;
    logic                  win_found;
    logic [CW-1:0]         win_ch, cand;
    logic                  grant;
    logic                  dp_en_q;
    logic signed [W-1:0]   dp_phase_q;
    logic [CW-1:0]         dp_ch_q;
    logic [LATENCY-1:0]    tag_v_q;
    logic [CW-1:0]         tag_ch_q [LATENCY];
    logic                  due_v;
    logic [CW-1:0]         due_ch;
    logic                  out_valid_q;
    logic signed [RW-1:0]  out_data_q;
    logic [CW-1:0]         out_ch_q;
    logic                  err_orphan_q, err_missing_q;

    assign accept = ch_valid & ~full_q;

    // Capture accepted samples; full_q guards the contents, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (accept[i]) hold_q[i] <= ch_phase[i*W +: W];
        end
    end

    // Occupancy: set on accept, cleared in the cycle the sample is strobed out.
    always_comb begin
        full_d = full_q | accept;
        if (state_q == S_ISSUE) full_d[dp_ch_q] = 1'b0;
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) full_q <= '0;
        else     full_q <= full_d;
    end

    // Round-robin search beginning just after the last granted channel.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        cand      = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(rr_q) + k) % NCH);
            if (!win_found && full_q[cand]) begin
                win_found = 1'b1;
                win_ch    = cand;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // FSM next state: the IDLE decision is registered so the strobe coincides with ISSUE.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        grant   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run && win_found) begin
                    grant   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (GAP == 1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    gap_d   = GAP_LOAD;
                end
            end
            S_WAIT: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Issue register: strobe, sample and context select for the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_en_q    <= 1'b0;
            dp_phase_q <= '0;
            dp_ch_q    <= '0;
            rr_q       <= CW'(NCH - 1);
        end else begin
            dp_en_q <= grant;
            if (grant) begin
                dp_phase_q <= hold_q[win_ch];
                dp_ch_q    <= win_ch;
                rr_q       <= win_ch;
            end
        end
    end

    // Tag valid pipeline; a bubble enters whenever no strobe is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q <= '0;
        end else begin
            tag_v_q[0] <= dp_en_q;
            for (int i = 1; i < LATENCY; i++) tag_v_q[i] <= tag_v_q[i-1];
        end
    end

    // Tag channel pipeline; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        tag_ch_q[0] <= dp_ch_q;
        for (int i = 1; i < LATENCY; i++) tag_ch_q[i] <= tag_ch_q[i-1];
    end

    assign due_v  = tag_v_q[LATENCY-1];
    assign due_ch = tag_ch_q[LATENCY-1];

    // Match the due tag against the result strobe; mismatches raise sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_ch_q      <= '0;
            err_orphan_q  <= 1'b0;
            err_missing_q <= 1'b0;
        end else begin
            out_valid_q <= due_v && dp_res_en;
            if (due_v && dp_res_en) begin
                out_data_q <= dp_res;
                out_ch_q   <= due_ch;
            end
            if (!due_v && dp_res_en) err_orphan_q  <= 1'b1;
            if (due_v && !dp_res_en) err_missing_q <= 1'b1;
        end
    end

    assign ch_ready    = ~full_q;
    assign dp_en       = dp_en_q;
    assign dp_phase    = dp_phase_q;
    assign dp_ch       = dp_ch_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign err_orphan  = err_orphan_q;
    assign err_missing = err_missing_q;
    assign busy        = (|full_q) | (|tag_v_q) | (state_q != S_IDLE);

endmodule

// File: tb/tb_phase_unwrap_scheduler.sv
// Bench for phase_unwrap_scheduler: a cycle-level reference model built from
// the timing rules, a fake datapath that answers each strobe after LATENCY
// cycles, and one task per scenario.
`timescale 1ns/1ps
module tb_phase_unwrap_scheduler;
    localparam int NCH = 4, W = 32, RW = 16, LAT = 7, GAP = 2, CW = 2;

    logic             clk = 1'b0, rst = 1'b1, run = 1'b0;
    logic [NCH*W-1:0] ch_phase = '0;
    logic [NCH-1:0]   ch_valid = '0, ch_ready;
    logic [W-1:0]     dp_phase;
    logic             dp_en;
    logic [CW-1:0]    dp_ch;
    logic [RW-1:0]    dp_res = '0;
    logic             dp_res_en = 1'b0;
    logic [RW-1:0]    out_data;
    logic [CW-1:0]    out_ch;
    logic             out_valid, busy, err_orphan, err_missing;

    int tests_run = 0, tests_failed = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    phase_unwrap_scheduler #(.NCH(NCH), .W(W), .RW(RW), .LATENCY(LAT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .run(run), .ch_phase(ch_phase), .ch_valid(ch_valid),
        .ch_ready(ch_ready), .dp_phase(dp_phase), .dp_en(dp_en), .dp_ch(dp_ch),
        .dp_res(dp_res), .dp_res_en(dp_res_en), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .busy(busy), .err_orphan(err_orphan), .err_missing(err_missing)
    );

    // ---------------- fake datapath ----------------
    int          dq[$];
    bit          dp_mute = 0, inj_orphan = 0, dp_fixed_en = 0;
    logic [RW-1:0] dp_fixed = '0;

    always @(negedge clk) begin
        #1;
        dp_res_en = 1'b0;
        dp_res    = dp_fixed_en ? dp_fixed : RW'($urandom);
        if (dq.size() > 0 && dq[0] == cyc) begin
            void'(dq.pop_front());
            if (!dp_mute) dp_res_en = 1'b1;
        end
        if (inj_orphan) dp_res_en = 1'b1;
    end

    // ---------------- reference model ----------------
    typedef struct { int c; int ch; } tag_t;
    tag_t         iq[$];
    bit           m_full[NCH];
    logic [W-1:0] m_hold[NCH];
    int           m_rr, m_next_ok, m_last_c;
    bit           e_dp_en, e_out_valid, e_orphan, e_missing;
    int           e_dp_ch, e_out_ch;
    logic [W-1:0] e_dp_phase;
    logic [RW-1:0] e_out_data;

    always @(posedge clk) begin
        bit   pre_full[NCH];
        bit   due;
        int   w;
        tag_t t;
        if (rst) begin
            foreach (m_full[i]) m_full[i] = 0;
            m_rr = NCH - 1; m_next_ok = 0; m_last_c = -100; iq.delete(); dq.delete();
            e_dp_en = 0; e_dp_ch = 0; e_dp_phase = '0;
            e_out_valid = 0; e_out_ch = 0; e_out_data = '0; e_orphan = 0; e_missing = 0;
        end else begin
            due = (iq.size() > 0) && (iq[0].c + LAT == cyc);
            e_out_valid = due && dp_res_en;
            if (due && dp_res_en) begin e_out_data = dp_res; e_out_ch = iq[0].ch; end
            if (!due && dp_res_en) e_orphan = 1;
            if (due && !dp_res_en) e_missing = 1;
            if (due) void'(iq.pop_front());
            pre_full = m_full;
            if (e_dp_en) begin
                m_full[e_dp_ch] = 0;
                t.c = cyc; t.ch = e_dp_ch; iq.push_back(t);
            end
            for (int i = 0; i < NCH; i++)
                if (ch_valid[i] && !pre_full[i]) begin m_full[i] = 1; m_hold[i] = ch_phase[i*W +: W]; end
            e_dp_en = 0;
            if (run && cyc >= m_next_ok) begin
                w = -1;
                for (int j = 1; j <= NCH; j++)
                    if (w < 0 && pre_full[(m_rr + j) % NCH]) w = (m_rr + j) % NCH;
                if (w >= 0) begin
                    e_dp_en = 1; e_dp_ch = w; e_dp_phase = m_hold[w];
                    m_rr = w; m_next_ok = cyc + 1 + GAP; m_last_c = cyc + 1;
                end
            end
            if (dp_en) dq.push_back(cyc + LAT);
        end
        cyc++;
    end

    function automatic bit e_busy();
        bit b = (iq.size() > 0) || (cyc >= m_last_c && cyc < m_last_c + GAP);
        foreach (m_full[i]) b |= m_full[i];
        return b;
    endfunction

    // ---------------- utilities ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; run = 0; ch_valid = '0; dp_mute = 0; inj_orphan = 0; dp_fixed_en = 0;
        tick(); tick();
        rst = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        tests_run++; if (ch_ready !== 4'hF) begin tests_failed++; $display("FAIL reset_ch_ready got %h want f", ch_ready); end
        tests_run++; if (dp_en !== 1'b0) begin tests_failed++; $display("FAIL reset_dp_en got %b want 0", dp_en); end
        tests_run++; if (dp_phase !== '0) begin tests_failed++; $display("FAIL reset_dp_phase got %h want 0", dp_phase); end
        tests_run++; if (dp_ch !== '0) begin tests_failed++; $display("FAIL reset_dp_ch got %h want 0", dp_ch); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tests_run++; if (out_ch !== '0) begin tests_failed++; $display("FAIL reset_out_ch got %h want 0", out_ch); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (err_orphan !== 1'b0) begin tests_failed++; $display("FAIL reset_err_orphan got %b want 0", err_orphan); end
        tests_run++; if (err_missing !== 1'b0) begin tests_failed++; $display("FAIL reset_err_missing got %b want 0", err_missing); end
    endtask

    task automatic test_single();
        do_reset();
        run = 1; dp_fixed_en = 1; dp_fixed = 16'h00AB;
        ch_phase[2*W +: W] = 32'h12345678; ch_valid = 4'b0100;
        for (int n = 1; n <= 12; n++) begin
            tick();
            ch_valid = '0;
            tests_run++; if (dp_en !== (n == 2)) begin tests_failed++; $display("FAIL single_dp_en n=%0d got %b want %b", n, dp_en, n == 2); end
            if (n == 2) begin
                tests_run++; if (dp_ch !== 2'd2) begin tests_failed++; $display("FAIL single_dp_ch got %0d want 2", dp_ch); end
                tests_run++; if (dp_phase !== 32'h12345678) begin tests_failed++; $display("FAIL single_dp_phase got %h want 12345678", dp_phase); end
            end
            if (n == 1) begin
                tests_run++; if (ch_ready !== 4'b1011) begin tests_failed++; $display("FAIL single_ready_full got %b want 1011", ch_ready); end
            end
            if (n == 3) begin
                tests_run++; if (ch_ready !== 4'hF) begin tests_failed++; $display("FAIL single_ready_back got %b want 1111", ch_ready); end
            end
            tests_run++; if (out_valid !== (n == 10)) begin tests_failed++; $display("FAIL single_out_valid n=%0d got %b want %b", n, out_valid, n == 10); end
            if (n == 10) begin
                tests_run++; if (out_ch !== 2'd2 || out_data !== 16'h00AB) begin tests_failed++; $display("FAIL single_out got ch%0d %h want ch2 00ab", out_ch, out_data); end
            end
        end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_end got %b want 0", busy); end
    endtask

    task automatic test_fairness();
        int prev_c = -1, prev_ch = -1, n_iss = 0;
        logic [NCH-1:0] er;
        do_reset();
        run = 1;
        for (int i = 0; i < 70; i++) begin
            ch_valid = (i < 45) ? 4'hF : 4'h0;
            for (int c = 0; c < NCH; c++) ch_phase[c*W +: W] = $urandom;
            tick();
            for (int c = 0; c < NCH; c++) er[c] = !m_full[c];
            tests_run++; if (ch_ready !== er) begin tests_failed++; $display("FAIL fair_ready cyc=%0d got %b want %b", cyc, ch_ready, er); end
            tests_run++; if (dp_en !== e_dp_en) begin tests_failed++; $display("FAIL fair_dp_en cyc=%0d got %b want %b", cyc, dp_en, e_dp_en); end
            if (dp_en === 1'b1) begin
                tests_run++;
                if (dp_ch !== CW'(e_dp_ch) || dp_phase !== e_dp_phase) begin
                    tests_failed++; $display("FAIL fair_issue cyc=%0d got ch%0d %h want ch%0d %h", cyc, dp_ch, dp_phase, e_dp_ch, e_dp_phase);
                end
                if (prev_c >= 0) begin
                    tests_run++;
                    if (dp_ch !== CW'((prev_ch + 1) % NCH) || cyc - prev_c != GAP + 1) begin
                        tests_failed++; $display("FAIL fair_order got ch%0d after %0d cycles want ch%0d after %0d", dp_ch, cyc - prev_c, (prev_ch + 1) % NCH, GAP + 1);
                    end
                end
                prev_c = cyc; prev_ch = int'(dp_ch); n_iss++;
            end
            tests_run++; if (out_valid !== e_out_valid) begin tests_failed++; $display("FAIL fair_out_valid cyc=%0d got %b want %b", cyc, out_valid, e_out_valid); end
            if (out_valid === 1'b1) begin
                tests_run++;
                if (out_ch !== CW'(e_out_ch) || out_data !== e_out_data) begin
                    tests_failed++; $display("FAIL fair_out cyc=%0d got ch%0d %h want ch%0d %h", cyc, out_ch, out_data, e_out_ch, e_out_data);
                end
            end
            tests_run++; if (busy !== e_busy()) begin tests_failed++; $display("FAIL fair_busy cyc=%0d got %b want %b", cyc, busy, e_busy()); end
        end
        tests_run++; if (n_iss < 14) begin tests_failed++; $display("FAIL fair_issue_count got %0d want >=14", n_iss); end
        tests_run++; if (err_orphan !== 1'b0 || err_missing !== 1'b0) begin tests_failed++; $display("FAIL fair_errors got %b%b want 00", err_orphan, err_missing); end
    endtask

    task automatic test_run_gating();
        logic [W-1:0] d1, d3;
        int seen_c[$], seen_ch[$];
        logic [W-1:0] seen_ph[$];
        do_reset();
        d1 = $urandom; d3 = $urandom;
        ch_phase[1*W +: W] = d1; ch_phase[3*W +: W] = d3; ch_valid = 4'b1010;
        tick();
        ch_valid = '0;
        for (int n = 0; n < 20; n++) begin
            tests_run++;
            if (dp_en !== 1'b0 || busy !== 1'b1 || ch_ready !== 4'b0101) begin
                tests_failed++; $display("FAIL gate_hold n=%0d got en=%b busy=%b ready=%b want 0 1 0101", n, dp_en, busy, ch_ready);
            end
            tick();
        end
        run = 1;
        for (int n = 0; n < 10; n++) begin
            tick();
            tests_run++; if (dp_en !== e_dp_en) begin tests_failed++; $display("FAIL gate_dp_en cyc=%0d got %b want %b", cyc, dp_en, e_dp_en); end
            if (dp_en === 1'b1) begin seen_c.push_back(cyc); seen_ch.push_back(int'(dp_ch)); seen_ph.push_back(dp_phase); end
        end
        tests_run++;
        if (seen_c.size() != 2) begin
            tests_failed++; $display("FAIL gate_count got %0d issues want 2", seen_c.size());
        end else begin
            if (seen_ch[0] != 1 || seen_ch[1] != 3 || seen_ph[0] !== d1 || seen_ph[1] !== d3 || seen_c[1] - seen_c[0] != 3) begin
                tests_failed++;
                $display("FAIL gate_order got ch%0d,ch%0d gap %0d want ch1,ch3 gap 3 (data %h %h want %h %h)", seen_ch[0], seen_ch[1], seen_c[1] - seen_c[0], seen_ph[0], seen_ph[1], d1, d3);
            end
        end
    endtask

    task automatic test_errors();
        bit found = 0;
        do_reset();
        inj_orphan = 1;
        tick();
        inj_orphan = 0;
        for (int n = 0; n < 6; n++) begin
            tests_run++;
            if (err_orphan !== 1'b1 || err_orphan !== e_orphan || err_missing !== 1'b0 || out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL err_orphan n=%0d got o=%b m=%b v=%b want 1 0 0", n, err_orphan, err_missing, out_valid);
            end
            tick();
        end
        dp_mute = 1; run = 1;
        ch_phase[0 +: W] = $urandom; ch_valid = 4'b0001;
        tick();
        ch_valid = '0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (dp_en === 1'b1) found = 1;
            else tick();
        end
        tests_run++;
        if (!found) begin
            tests_failed++; $display("FAIL err_issue_timeout got no dp_en want one within 8 cycles");
        end else begin
            for (int n = 1; n <= LAT + 3; n++) begin
                tick();
                tests_run++;
                if (err_missing !== (n >= LAT + 1) || err_missing !== e_missing || out_valid !== 1'b0) begin
                    tests_failed++; $display("FAIL err_missing n=%0d got m=%b v=%b want m=%b v=0", n, err_missing, out_valid, n >= LAT + 1);
                end
            end
            tests_run++; if (err_orphan !== 1'b1) begin tests_failed++; $display("FAIL err_orphan_sticky got %b want 1", err_orphan); end
        end
    endtask

    task automatic test_reset_midflight();
        int cnt = 0;
        do_reset();
        run = 1;
        for (int c = 0; c < NCH; c++) ch_phase[c*W +: W] = $urandom;
        ch_valid = 4'b0111;
        tick();
        ch_valid = '0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            if (dp_en === 1'b1) cnt++;
            if (cnt < 3) tick();
        end
        tests_run++;
        if (cnt < 3) begin tests_failed++; $display("FAIL mid_issue_timeout got %0d issues want 3", cnt); end
        rst = 1;
        tick();
        rst = 0;
        tests_run++; if (ch_ready !== 4'hF) begin tests_failed++; $display("FAIL mid_ch_ready got %h want f", ch_ready); end
        tests_run++; if (dp_en !== 1'b0 || dp_phase !== '0 || dp_ch !== '0) begin tests_failed++; $display("FAIL mid_dp got en=%b ph=%h ch=%0d want 0 0 0", dp_en, dp_phase, dp_ch); end
        tests_run++; if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin tests_failed++; $display("FAIL mid_out got v=%b d=%h ch=%0d want 0 0 0", out_valid, out_data, out_ch); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %b want 0", busy); end
        tests_run++; if (err_orphan !== 1'b0 || err_missing !== 1'b0) begin tests_failed++; $display("FAIL mid_err got %b%b want 00", err_orphan, err_missing); end
        for (int n = 0; n < 15; n++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0 || dp_en !== 1'b0 || busy !== 1'b0) begin
                tests_failed++; $display("FAIL mid_quiet n=%0d got v=%b en=%b busy=%b want 0 0 0", n, out_valid, dp_en, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp[$];
        int  val = 1000, issues = 0;
        bit  prev_ready = 0;
        do_reset();
        run = 1; ch_valid = 4'b0001; ch_phase[0 +: W] = val;
        for (int n = 0; n < 75; n++) begin
            prev_ready = ch_valid[0] && ch_ready[0];
            tick();
            if (prev_ready) begin exp.push_back(W'(val)); val++; end
            if (n >= 60) ch_valid = '0;
            ch_phase[0 +: W] = val;
            if (dp_en === 1'b1) begin
                tests_run++;
                if (exp.size() == 0) begin
                    tests_failed++; $display("FAIL b2b_dup got %h want no issue", dp_phase);
                end else begin
                    if (dp_phase !== exp[0] || dp_ch !== 2'd0) begin
                        tests_failed++; $display("FAIL b2b_data got ch%0d %h want ch0 %h", dp_ch, dp_phase, exp[0]);
                    end
                    void'(exp.pop_front());
                end
                issues++;
            end
        end
        tests_run++; if (exp.size() != 0) begin tests_failed++; $display("FAIL b2b_loss got %0d pending want 0", exp.size()); end
        tests_run++; if (issues < 18) begin tests_failed++; $display("FAIL b2b_count got %0d issues want >=18", issues); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_run_gating();
        test_errors();
        test_reset_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/phase_unwrap_scheduler.md
# phase_unwrap_scheduler

Round-robin scheduler that shares one phase-unwrap (phase-jump correction) datapath between NCH interferometer channels. It accepts raw phase samples from each channel over valid/ready, issues them to the datapath as single-cycle enable pulses tagged with a channel index, and tracks each issue through the datapath's fixed latency. Each result is returned tagged with the channel it belongs to. The datapath keeps one accumulator/previous-phase context per channel, selected by `dp_ch`. The scheduler sits between the per-channel phase demodulators and the unwrap unit.

## Interface
- NCH, 4: number of channels; CW = clog2(NCH).
- W, 32: raw phase sample width, signed fixed-point, passed through unmodified.
- RW, 16: result width (fixed-point phase from datapath).
- LATENCY, 7: cycles from `dp_en` high to the matching `dp_res_en` high; range 1..31.
- GAP, 2: minimum cycles between successive `dp_en` pulses; range 1..8.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  issue enable; 0 stops new issues, in-flight results still drain.
- ch_phase  in  NCH*W  channel i sample at bits [i*W +: W].
- ch_valid  in  NCH  per-channel sample valid.
- ch_ready  out  NCH  per-channel holding register empty.
- dp_phase  out  W  sample to datapath (registered).
- dp_en  out  1  single-cycle issue strobe (registered).
- dp_ch  out  CW  context select for the datapath, valid with `dp_en`.
- dp_res  in  RW  datapath result.
- dp_res_en  in  1  datapath result strobe.
- out_data  out  RW  tagged result (registered).
- out_ch  out  CW  channel of `out_data`.
- out_valid  out  1  single-cycle result strobe; no backpressure.
- busy  out  1  any holding register full, any tag in flight, or FSM not IDLE.
- err_orphan  out  1  sticky: `dp_res_en` with no tag due.
- err_missing  out  1  sticky: tag due with no `dp_res_en`.

## Operation
- Per-channel one-entry holding register. Accept on `ch_valid[i] && ch_ready[i]`. `ch_ready[i] = ~full[i]`. A channel's register clears in the cycle it is issued, so a new sample can be accepted the next cycle.
- Round-robin arbitration:
  - Pointer `rr` holds the last granted channel (reset NCH-1).
  - Search order is rr+1, rr+2, … modulo NCH; the first full register wins.
  - `rr` is updated only on an issue.
- FSM:
  - IDLE: if `run` and any register is full, go to ISSUE; otherwise stay.
  - ISSUE: one cycle. Latch `dp_phase`/`dp_ch` from the winner, pulse `dp_en`, clear `full[winner]`, push tag {1, winner}. If GAP=1, go to IDLE; otherwise go to WAIT with gap counter = GAP-1.
  - WAIT: decrement the counter; at 1, go to IDLE.
- An arbitration decision made in IDLE is registered into ISSUE. The winner cannot change, because a full register only clears on its own issue. Samples accepted during ISSUE or WAIT join the next arbitration.
- Tag pipeline: shift register of LATENCY entries {v, ch}. It advances every cycle and a bubble (v=0) is inserted when no issue occurs. The tail entry is "due".
- Result routing, evaluated each cycle on the due entry and `dp_res_en`:
  - due.v && dp_res_en: `out_valid`=1 next cycle, `out_data`=`dp_res`, `out_ch`=due.ch.
  - !due.v && dp_res_en: set `err_orphan`, no output.
  - due.v && !dp_res_en: set `err_missing`, drop the tag, no output.
- Sticky errors clear only on `rst`.
- `run` deasserted in WAIT: the current WAIT completes, then the FSM holds in IDLE. Holding registers keep their data.

## Timing
- Reset values: `ch_ready` all 1, `dp_en` 0, `dp_phase` 0, `dp_ch` 0, `out_valid` 0, `out_data` 0, `out_ch` 0, `busy` 0, `err_orphan` 0, `err_missing` 0. Holding registers empty, tags all invalid, FSM IDLE, `rr` = NCH-1.
- Accept at cycle t → earliest `dp_en` at t+2 (IDLE at t+1 sees the full register, ISSUE output registered at t+2).
- `dp_en` at cycle c → `dp_res_en` is expected at c+LATENCY → `out_valid` at c+LATENCY+1.
- Issue throughput: one issue per GAP+1 cycles while requests are pending (IDLE counts as one cycle). GAP=2 gives one issue every 3 cycles.
- Simultaneous accept and issue on the same channel cannot occur, because `ch_ready` is 0 while full.
- `rst` asserted mid-operation: all state returns to reset values on the next edge. In-flight tags are discarded, and later datapath strobes raise `err_orphan` only if they arrive after reset deasserts.

## Test plan
- Single sample: ch2 presents 0x12345678 at t0, run=1 → `dp_en` at t0+2 with `dp_ch`=2 and `dp_phase`=0x12345678; drive `dp_res_en` with 0x00AB at t0+9 → `out_valid` at t0+10 with `out_ch`=2 and `out_data`=0x00AB.
- Fairness: all 4 channels continuously valid, GAP=2 → `dp_ch` sequence 0,1,2,3,0,… with `dp_en` spaced exactly 3 cycles; each `ch_ready` reasserts the cycle after its issue.
- run gating: fill ch1 and ch3, hold run=0 for 20 cycles → no `dp_en`, `busy`=1, `ch_ready`=4'b0101; raise run → ch1 issued, then ch3, 3 cycles apart.
- Error detection: drive `dp_res_en` with no prior issue → `err_orphan`=1 and stays 1; issue one sample and withhold `dp_res_en` → `err_missing`=1 at issue+LATENCY+1, no `out_valid`.
- Reset mid-flight: issue 3 samples, assert `rst` for 1 cycle before any result → every output is at its reset value, `busy`=0, and no `out_valid` follows.
- Back-to-back reload: ch0 valid every cycle with incrementing data, other channels idle → every sample reaches `dp_phase` in order with no loss and no duplication.
